serial_to_parallel_rx: RTL and testbench

- Receive-side partner of the team's parallel-to-serial shifter. It consumes the single-bit serial stream produced upstream and re-assembles N-bit words.
- Frame on the wire: one start bit (1), then N data bits LSB first, then one stop bit (0). The line idles at 0.
- Bits are sampled only on a shared bit strobe (shift). Completed words go to the downstream consumer through a valid/ack handshake, with sticky overrun and framing-error flags.

---
 rtl/serial_to_parallel_rx.sv | 160 ++++++++++++++++
 tb/tb_serial_to_parallel_rx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel_rx.sv
// Serial-to-parallel receiver: start(1) + N data bits LSB first + stop(0), sampled on EN&shift.
// Latency: Q/valid update on the edge that samples the stop bit, visible the following cycle.
// Backpressure: valid/ack single-entry slot; a word completing into a full slot is dropped and sets ovr.
module serial_to_parallel_rx #(
  parameter int N = 4
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         EN,
  input  logic         shift,
  input  logic         S,
  input  logic         ack,
  input  logic         clr_err,
  output logic [N-1:0] Q,
  output logic         valid,
  output logic         busy,
  output logic         ovr,
  output logic         ferr
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  // Frame reception state
  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_sr;

  // Output slot and sticky flags
  logic [N-1:0]    r_q;
  logic            r_valid;
  logic            r_ovr;
  logic            r_ferr;

  // Next-state values
  state_t          w_state_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [N-1:0]    w_sr_nxt;
  logic [N-1:0]    w_q_nxt;
  logic            w_valid_nxt;
  logic            w_ovr_nxt;
  logic            w_ferr_nxt;

  // Per-cycle events
  logic            w_strobe;
  logic            w_stop_ok;
  logic            w_stop_bad;
  logic            w_ack_take;
  logic            w_slot_free;
  logic            w_ovr_set;
  logic            w_clr;

  assign w_strobe    = EN & shift;
  // Consumption only counts while a word is actually held and the block is enabled.
  assign w_ack_take  = EN & ack & r_valid;
  // Slot can take a new word if empty, or if it is being drained on this same edge.
  assign w_slot_free = ~r_valid | w_ack_take;
  assign w_clr       = EN & clr_err;

  // Register FSM state, bit counter and shift register
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sr    <= w_sr_nxt;
    end
  end

  // Next-state logic: transitions only on strobe cycles; stop bit outcome decoded in STOP
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sr_nxt    = r_sr;
    w_stop_ok   = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_strobe && S) begin
          w_state_nxt = ST_DATA;
          w_cnt_nxt   = '0;
        end
      end
      ST_DATA: begin
        if (w_strobe) begin
          w_sr_nxt = {S, r_sr[N-1:1]};
          if (r_cnt == CW'(N - 1)) begin
            // Last data bit: park the counter at 0 rather than letting it wrap.
            w_state_nxt = ST_STOP;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (w_strobe) begin
          // A stop bit of 1 is a framing error; it is never taken as a new start bit.
          w_state_nxt = ST_IDLE;
          w_stop_ok   = ~S;
          w_stop_bad  = S;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output slot: load completed word, drop on overrun, clear on ack
  always_comb begin
    w_q_nxt     = r_q;
    w_valid_nxt = r_valid;
    w_ovr_set   = 1'b0;
    if (w_stop_ok && w_slot_free) begin
      w_q_nxt     = r_sr;
      w_valid_nxt = 1'b1;
    end else if (w_stop_ok) begin
      w_ovr_set = 1'b1;
    end else if (w_ack_take) begin
      w_valid_nxt = 1'b0;
    end
  end

  // Sticky flags: a set event in the clear cycle wins
  always_comb begin
    w_ovr_nxt  = (r_ovr  & ~w_clr) | w_ovr_set;
    w_ferr_nxt = (r_ferr & ~w_clr) | w_stop_bad;
  end

  // Register output slot and error flags
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_q     <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_q     <= w_q_nxt;
      r_valid <= w_valid_nxt;
      r_ovr   <= w_ovr_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  assign Q     = r_q;
  assign valid = r_valid;
  assign busy  = (r_state != ST_IDLE);
  assign ovr   = r_ovr;
  assign ferr  = r_ferr;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Self-checking bench for serial_to_parallel_rx with a frame-level reference model.
// Latency: expected words are pushed when the model completes a frame; popped on consumer ack.
// Backpressure: random ack and EN drops exercise overrun, simultaneous ack and freeze paths.
module tb_serial_to_parallel_rx;

  localparam int N = 4;

  logic         CLK = 1'b0;
  logic         Reset = 1'b1;
  logic         EN = 1'b0;
  logic         shift = 1'b0;
  logic         S = 1'b0;
  logic         ack = 1'b0;
  logic         clr_err = 1'b0;
  logic [N-1:0] Q;
  logic         valid;
  logic         busy;
  logic         ovr;
  logic         ferr;

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  // Reference model state (frame level)
  int           mbits[$];
  bit           in_frame = 1'b0;
  logic [N-1:0] mq = '0;
  bit           mv = 1'b0;
  bit           movr = 1'b0;
  bit           mferr = 1'b0;
  logic [N-1:0] expq[$];

  serial_to_parallel_rx #(.N(N)) dut (
    .CLK     (CLK),
    .Reset   (Reset),
    .EN      (EN),
    .shift   (shift),
    .S       (S),
    .ack     (ack),
    .clr_err (clr_err),
    .Q       (Q),
    .valid   (valid),
    .busy    (busy),
    .ovr     (ovr),
    .ferr    (ferr)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model the effect of one clock edge given the inputs that were held across it.
  task automatic model_edge(input logic en, input logic sh, input logic s,
                            input logic ak, input logic cl, input logic rst);
    logic [N-1:0] word;
    bit done;
    bit stop;
    bit ovr_set;
    bit ferr_set;
    word = '0; done = 0; stop = 0; ovr_set = 0; ferr_set = 0;
    if (rst) begin
      in_frame = 0; mbits.delete(); mq = '0; mv = 0; movr = 0; mferr = 0; expq.delete();
      return;
    end
    if (!en) return;
    if (sh) begin
      if (!in_frame) begin
        if (s) begin
          in_frame = 1;
          mbits.delete();
        end
      end else begin
        mbits.push_back(int'(s));
        if (mbits.size() == N + 1) begin
          in_frame = 0;
          done = 1;
          for (int i = 0; i < N; i++) word[i] = mbits[i][0];
          stop = mbits[N][0];
        end
      end
    end
    if (done && !stop) begin
      if (!mv || ak) begin
        mq = word;
        mv = 1;
        expq.push_back(word);
      end else begin
        ovr_set = 1;
      end
    end else begin
      if (done) ferr_set = 1;
      if (ak && mv) mv = 0;
    end
    if (cl) begin
      movr = 0;
      mferr = 0;
    end
    if (ovr_set) movr = 1;
    if (ferr_set) mferr = 1;
  endtask

  task automatic step(input logic en, input logic sh, input logic s,
                      input logic ak, input logic cl, input logic rst);
    EN = en; shift = sh; S = s; ack = ak; clr_err = cl; Reset = rst;
    @(posedge CLK);
    model_edge(en, sh, s, ak, cl, rst);
    #1;
  endtask

  task automatic strobe(input logic s, input logic ak);
    step(1, 1, s, ak, 0, 0);
  endtask

  task automatic frame(input logic [N-1:0] d, input logic stop, input logic ack_at_stop);
    strobe(1, 0);
    for (int i = 0; i < N; i++) strobe(d[i], 0);
    strobe(stop, ack_at_stop);
  endtask

  task automatic rstep(input logic sh, input logic s);
    logic en;
    en = ($urandom_range(0, 5) != 0);
    step(en, sh, s, $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, 0);
  endtask

  // Random bit: retry until the strobe lands with EN=1, then random idle gap.
  task automatic rbit(input logic s);
    logic en;
    do begin
      en = ($urandom_range(0, 5) != 0);
      step(en, 1, s, $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, 0);
    end while (!en);
    repeat ($urandom_range(0, 2)) rstep($urandom_range(0, 1) == 0 ? 1'b0 : 1'b0, 1'b0);
  endtask

  // Monitor: compare observable state every cycle; pop scoreboard on each consumed word.
  always @(negedge CLK) begin
    if (mon_on) begin
      chk("valid", 32'(valid), 32'(mv));
      chk("Q", 32'(Q), 32'(mq));
      chk("busy", 32'(busy), 32'(in_frame));
      chk("ovr", 32'(ovr), 32'(movr));
      chk("ferr", 32'(ferr), 32'(mferr));
      if (valid === 1'b1 && ack && EN && !Reset) begin
        if (expq.size() == 0) begin
          chk("sb_pop_empty", 32'(expq.size()), 32'd1);
        end else begin
          chk("sb_word", 32'(Q), 32'(expq.pop_front()));
        end
      end
    end
  end

  logic [N-1:0] bitsv;

  initial begin
    // Reset state
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    chk("rst_Q", 32'(Q), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovr", 32'(ovr), 32'd0);
    chk("rst_ferr", 32'(ferr), 32'd0);
    mon_on = 1'b1;

    // Basic frame
    strobe(1, 0);
    chk("basic_busy_after_start", 32'(busy), 32'd1);
    strobe(0, 0); strobe(1, 0); strobe(0, 0); strobe(1, 0);
    chk("basic_valid_before_stop", 32'(valid), 32'd0);
    strobe(0, 0);
    chk("basic_Q", 32'(Q), 32'hA);
    chk("basic_valid", 32'(valid), 32'd1);
    chk("basic_busy_after_stop", 32'(busy), 32'd0);

    // Handshake
    step(1, 0, 0, 1, 0, 0);
    chk("hs_valid_clear", 32'(valid), 32'd0);
    chk("hs_Q_hold", 32'(Q), 32'hA);
    frame(4'h3, 0, 0);
    chk("hs_Q3", 32'(Q), 32'h3);
    chk("hs_valid3", 32'(valid), 32'd1);

    // Overrun and simultaneous ack
    step(1, 0, 0, 1, 0, 0);
    frame(4'hA, 0, 0);
    frame(4'h5, 0, 0);
    chk("ovr_Q_kept", 32'(Q), 32'hA);
    chk("ovr_set", 32'(ovr), 32'd1);
    frame(4'h5, 0, 1);
    chk("simack_Q", 32'(Q), 32'h5);
    chk("simack_valid", 32'(valid), 32'd1);
    step(1, 0, 0, 0, 1, 0);
    chk("clr_ovr", 32'(ovr), 32'd0);

    // Framing error
    frame(4'hF, 1, 0);
    chk("ferr_set", 32'(ferr), 32'd1);
    chk("ferr_valid_kept", 32'(valid), 32'd1);
    chk("ferr_Q_kept", 32'(Q), 32'h5);
    chk("ferr_idle", 32'(busy), 32'd0);
    strobe(0, 0);
    chk("ferr_no_restart", 32'(busy), 32'd0);
    step(1, 0, 0, 1, 1, 0);

    // Idle gaps between strobes
    bitsv = 4'hC;
    strobe(1, 0); step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) begin
      strobe(bitsv[i], 0);
      step(1, 0, 1, 0, 0, 0);
    end
    strobe(0, 0);
    chk("gap_Q", 32'(Q), 32'hC);

    // EN drop mid-data: shift and ack during EN=0 are ignored
    strobe(1, 0); strobe(bitsv[0], 0); strobe(bitsv[1], 0);
    repeat (3) step(0, 1, 1, 1, 1, 0);
    chk("en_freeze_valid", 32'(valid), 32'd1);
    chk("en_freeze_busy", 32'(busy), 32'd1);
    step(1, 0, 0, 1, 0, 0);
    strobe(bitsv[2], 0); strobe(bitsv[3], 0); strobe(0, 0);
    chk("en_Q", 32'(Q), 32'hC);
    chk("en_no_ovr", 32'(ovr), 32'd0);

    // Reset mid-frame
    strobe(1, 0); strobe(1, 0); strobe(0, 0);
    step(1, 0, 0, 0, 0, 1);
    chk("midrst_Q", 32'(Q), 32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    frame(4'h9, 0, 0);
    chk("midrst_Q9", 32'(Q), 32'h9);
    chk("midrst_valid9", 32'(valid), 32'd1);

    // Randomized frames
    for (int f = 0; f < 250; f++) begin
      logic [N-1:0] d;
      logic stop;
      d = N'($urandom);
      stop = ($urandom_range(0, 9) == 0);
      repeat ($urandom_range(0, 3)) rstep($urandom_range(0, 1) == 1, 1'b0);
      rbit(1'b1);
      for (int i = 0; i < N; i++) rbit(d[i]);
      rbit(stop);
      if ($urandom_range(0, 49) == 0) step(1, 0, 0, 0, 0, 1);
    end

    // Drain remaining word
    for (int k = 0; k < 10 && mv; k++) step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("sb_empty", 32'(expq.size()), 32'd0);
    chk("final_valid", 32'(valid), 32'd0);

    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
